// File: rtl/axis_pattern_generator_pkg.sv
// Shared encodings and LFSR constants for the AXI-Stream pattern generator.
package axis_pattern_generator_pkg;

    typedef enum logic [1:0] {
        MODE_COUNTER = 2'd0,
        MODE_WALK    = 2'd1,
        MODE_LFSR    = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/axis_pattern_generator_lfsr.sv
// 32-bit Galois LFSR that steps only when advance_i is high.
// Only compiled when AXIS_PATTERN_GENERATOR_LFSR_EN is defined.
`ifdef AXIS_PATTERN_GENERATOR_LFSR_EN
module axis_pattern_generator_lfsr
    import axis_pattern_generator_pkg::*;
(
    input  logic        clk_i,
    input  logic        a_rst_n_i,
    input  logic        advance_i,
    output logic [31:0] state_o
);

    logic [31:0] state_reg;

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_reg <= LFSR_SEED;
        end else if (advance_i) begin
            state_reg <= lfsr_step(state_reg);
        end
    end

    assign state_o = state_reg;

endmodule
`endif

// File: rtl/axis_pattern_generator.sv
// AXI-Stream burst pattern generator (counter / walking-one / LFSR data).
// Define AXIS_PATTERN_GENERATOR_LFSR_EN to build the LFSR data mode.
module axis_pattern_generator
    import axis_pattern_generator_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int MAX_BURST       = 1024,
    parameter int GAP_WIDTH       = 8,
    localparam int LEN_W          = $clog2(MAX_BURST + 1),
    localparam int KEEP_W         = AXIS_DATA_WIDTH / 8
) (
    input  logic                       clk_i,
    input  logic                       a_rst_n_i,
    input  logic                       enable_i,
    input  logic [1:0]                 mode_i,
    input  logic [LEN_W-1:0]           burst_len_i,
    input  logic [GAP_WIDTH-1:0]       gap_i,
    input  logic [KEEP_W-1:0]          last_tkeep_i,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic [KEEP_W-1:0]          m_axis_tkeep_o,
    output logic                       m_axis_tvalid_o,
    output logic                       m_axis_tlast_o,
    input  logic                       m_axis_tready_i,
    output logic                       busy_o,
    output logic [31:0]                pkt_cnt_o
);

    state_e                     state_reg, state_next;
    mode_e                      mode_reg;
    logic [LEN_W-1:0]           len_reg, k_reg, len_clamped;
    logic [GAP_WIDTH-1:0]       gap_reg, gap_cnt_reg;
    logic [KEEP_W-1:0]          last_tkeep_reg;
    logic [31:0]                pkt_cnt_reg;
    logic                       handshake, last_beat, burst_done, can_start, load;
    logic [AXIS_DATA_WIDTH-1:0] cnt_data, walk_data, pattern;

    assign len_clamped = (32'(burst_len_i) > MAX_BURST) ? LEN_W'(MAX_BURST) : burst_len_i;
    assign can_start   = enable_i && (burst_len_i != '0);
    assign handshake   = (state_reg == ST_SEND) && m_axis_tready_i;
    assign last_beat   = (k_reg == len_reg - LEN_W'(1));
    assign burst_done  = handshake && last_beat;

    // State register
    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state; load marks the edge on which a new burst's configuration is captured
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (can_start) begin
                    state_next = ST_SEND;
                    load       = 1'b1;
                end
            end
            ST_SEND: begin
                if (burst_done) begin
                    if (!enable_i) begin
                        state_next = ST_IDLE;
                    end else if (gap_reg != '0) begin
                        state_next = ST_GAP;
                    end else if (can_start) begin
                        load = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == GAP_WIDTH'(1)) begin
                    if (can_start) begin
                        state_next = ST_SEND;
                        load       = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge a_rst_n_i) begin
        if (!a_rst_n_i) begin
            mode_reg       <= MODE_COUNTER;
            len_reg        <= '0;
            gap_reg        <= '0;
            last_tkeep_reg <= '0;
            k_reg          <= '0;
            gap_cnt_reg    <= '0;
            pkt_cnt_reg    <= '0;
        end else begin
            if (load) begin
                mode_reg       <= mode_e'(mode_i);
                len_reg        <= len_clamped;
                gap_reg        <= gap_i;
                last_tkeep_reg <= last_tkeep_i;
            end
            if (load) begin
                k_reg <= '0;
            end else if (handshake) begin
                k_reg <= last_beat ? '0 : k_reg + LEN_W'(1);
            end
            if (burst_done && (state_next == ST_GAP)) begin
                gap_cnt_reg <= gap_reg;
            end else if (state_reg == ST_GAP) begin
                gap_cnt_reg <= gap_cnt_reg - GAP_WIDTH'(1);
            end
            if (burst_done) begin
                pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
            end
        end
    end

    assign cnt_data  = AXIS_DATA_WIDTH'(k_reg);
    assign walk_data = {{(AXIS_DATA_WIDTH-1){1'b0}}, 1'b1} << (32'(k_reg) % AXIS_DATA_WIDTH);

`ifdef AXIS_PATTERN_GENERATOR_LFSR_EN
    logic [31:0]                lfsr_state;
    logic [AXIS_DATA_WIDTH-1:0] lfsr_data;

    axis_pattern_generator_lfsr u_lfsr (
        .clk_i     (clk_i),
        .a_rst_n_i (a_rst_n_i),
        .advance_i (handshake && (mode_reg == MODE_LFSR)),
        .state_o   (lfsr_state)
    );

    // Replicate the 32-bit state across the bus, truncating the top copy
    for (genvar gi = 0; gi < AXIS_DATA_WIDTH; gi++) begin : g_lfsr_rep
        assign lfsr_data[gi] = lfsr_state[gi % 32];
    end
`endif

    // Outputs derive from registers only, so they stay stable while stalled
    always_comb begin
        case (mode_reg)
            MODE_WALK: pattern = walk_data;
`ifdef AXIS_PATTERN_GENERATOR_LFSR_EN
            MODE_LFSR: pattern = lfsr_data;
`endif
            default:   pattern = cnt_data;
        endcase
        m_axis_tvalid_o = (state_reg == ST_SEND);
        m_axis_tlast_o  = m_axis_tvalid_o && last_beat;
        m_axis_tkeep_o  = m_axis_tvalid_o ? (last_beat ? last_tkeep_reg : '1) : '0;
        m_axis_tdata_o  = m_axis_tvalid_o ? pattern : '0;
        busy_o          = (state_reg != ST_IDLE);
    end

    assign pkt_cnt_o = pkt_cnt_reg;

endmodule

// File: tb/tb_axis_pattern_generator.sv
// Directed self-checking bench for axis_pattern_generator (32-bit data, MAX_BURST=6).
module tb_axis_pattern_generator;

    localparam int DW     = 32;
    localparam int MAXB   = 6;
    localparam int GW     = 8;
    localparam int LEN_W  = $clog2(MAXB + 1);
    localparam int KEEP_W = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic [LEN_W-1:0]  burst_len = '0;
    logic [GW-1:0]     gap = '0;
    logic [KEEP_W-1:0] last_tkeep = '0;
    logic [DW-1:0]     tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid, tlast, busy;
    logic              tready = 1'b0;
    logic [31:0]       pkt_cnt;

    int checks = 0;
    int passed = 0;
    int exp_pkt = 0;

    axis_pattern_generator #(
        .AXIS_DATA_WIDTH (DW),
        .MAX_BURST       (MAXB),
        .GAP_WIDTH       (GW)
    ) dut (
        .clk_i           (clk),
        .a_rst_n_i       (rst_n),
        .enable_i        (enable),
        .mode_i          (mode),
        .burst_len_i     (burst_len),
        .gap_i           (gap),
        .last_tkeep_i    (last_tkeep),
        .m_axis_tdata_o  (tdata),
        .m_axis_tkeep_o  (tkeep),
        .m_axis_tvalid_o (tvalid),
        .m_axis_tlast_o  (tlast),
        .m_axis_tready_i (tready),
        .busy_o          (busy),
        .pkt_cnt_o       (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic setup(input logic [1:0] m, input int len, input int g, input logic [3:0] keep);
        mode       = m;
        burst_len  = LEN_W'(len);
        gap        = GW'(g);
        last_tkeep = keep;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (tvalid !== 1'b0) $display("FAIL reset_tvalid got %b want 0", tvalid); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (tdata !== 32'h0 || tkeep !== 4'h0 || tlast !== 1'b0) $display("FAIL reset_data got %h/%h/%b want 0/0/0", tdata, tkeep, tlast); else passed++;
        checks++; if (pkt_cnt !== 32'd0) $display("FAIL reset_pkt got %0d want 0", pkt_cnt); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else passed++;
        $display("reset: outputs idle");
    endtask

    task automatic test_counter();
        setup(2'd0, 4, 0, 4'hF);
        tready = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++; if (tvalid !== 1'b1) $display("FAIL cnt_valid beat %0d got %b want 1", i, tvalid); else passed++;
            checks++; if (tdata !== 32'(i % 4)) $display("FAIL cnt_data beat %0d got %h want %h", i, tdata, 32'(i % 4)); else passed++;
            checks++; if (tlast !== (i % 4 == 3)) $display("FAIL cnt_last beat %0d got %b want %b", i, tlast, (i % 4 == 3)); else passed++;
            checks++; if (pkt_cnt !== 32'(exp_pkt + i / 4)) $display("FAIL cnt_pkt beat %0d got %0d want %0d", i, pkt_cnt, exp_pkt + i / 4); else passed++;
            $display("counter beat %0d data %h last %b", i, tdata, tlast);
            if (i == 7) enable = 1'b0;
            @(negedge clk);
        end
        exp_pkt += 2;
        checks++; if (tvalid !== 1'b0 || busy !== 1'b0) $display("FAIL cnt_stop got valid %b busy %b want 0 0", tvalid, busy); else passed++;
        checks++; if (pkt_cnt !== 32'(exp_pkt)) $display("FAIL cnt_pkt_end got %0d want %0d", pkt_cnt, exp_pkt); else passed++;
    endtask

    task automatic test_backpressure();
        int k = 0;
        int cyc = 0;
        setup(2'd0, 3, 0, 4'h3);
        tready = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        // Changed inputs after the start edge must not affect the running burst
        enable = 1'b0;
        last_tkeep = 4'hA;
        burst_len = LEN_W'(5);
        while (k < 3 && cyc < 12) begin
            checks++; if (tvalid !== 1'b1) $display("FAIL bp_valid cyc %0d got %b want 1", cyc, tvalid); else passed++;
            checks++; if (tdata !== 32'(k)) $display("FAIL bp_data cyc %0d got %h want %h", cyc, tdata, 32'(k)); else passed++;
            checks++; if (tkeep !== ((k == 2) ? 4'h3 : 4'hF)) $display("FAIL bp_keep cyc %0d got %h want %h", cyc, tkeep, ((k == 2) ? 4'h3 : 4'hF)); else passed++;
            checks++; if (tlast !== (k == 2)) $display("FAIL bp_last cyc %0d got %b want %b", cyc, tlast, (k == 2)); else passed++;
            $display("backpressure cyc %0d beat %0d data %h keep %h ready %b", cyc, k, tdata, tkeep, cyc[0]);
            tready = cyc[0];
            @(negedge clk);
            if (tready) k++;
            cyc++;
        end
        checks++; if (k != 3) $display("FAIL bp_timeout got %0d beats want 3", k); else passed++;
        exp_pkt += 1;
        tready = 1'b1;
        checks++; if (tvalid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_idle got valid %b busy %b want 0 0", tvalid, busy); else passed++;
        checks++; if (pkt_cnt !== 32'(exp_pkt)) $display("FAIL bp_pkt got %0d want %0d", pkt_cnt, exp_pkt); else passed++;
    endtask

    task automatic test_modes();
        logic [31:0] exp_d;
        setup(2'd1, 3, 0, 4'hF);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_d = (i == 0) ? 32'h1 : (i == 1) ? 32'h2 : 32'h4;
            checks++; if (tdata !== exp_d || tlast !== (i == 2)) $display("FAIL walk beat %0d got %h/%b want %h/%b", i, tdata, tlast, exp_d, (i == 2)); else passed++;
            $display("walk beat %0d data %h", i, tdata);
            @(negedge clk);
        end
        setup(2'd3, 2, 0, 4'hF);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (tdata !== 32'(i) || tvalid !== 1'b1) $display("FAIL rsvd beat %0d got %h/%b want %h/1", i, tdata, tvalid, 32'(i)); else passed++;
            $display("reserved-mode beat %0d data %h", i, tdata);
            @(negedge clk);
        end
        exp_pkt += 2;
        checks++; if (pkt_cnt !== 32'(exp_pkt)) $display("FAIL modes_pkt got %0d want %0d", pkt_cnt, exp_pkt); else passed++;
    endtask

    task automatic test_lfsr();
        logic [31:0] exp_d;
        setup(2'd2, 2, 0, 4'hF);
        enable = 1'b1;
        @(negedge clk);
        // Two back-to-back bursts: the sequence continues without reseeding
        for (int i = 0; i < 4; i++) begin
`ifdef AXIS_PATTERN_GENERATOR_LFSR_EN
            exp_d = (i == 0) ? 32'h0000_0001 : (i == 1) ? 32'h8020_0003 : (i == 2) ? 32'hC030_0002 : 32'h6018_0001;
`else
            exp_d = 32'(i % 2);
`endif
            checks++; if (tdata !== exp_d || tvalid !== 1'b1) $display("FAIL lfsr beat %0d got %h/%b want %h/1", i, tdata, tvalid, exp_d); else passed++;
            $display("lfsr beat %0d data %h", i, tdata);
            if (i == 2) enable = 1'b0;
            @(negedge clk);
        end
        exp_pkt += 2;
        checks++; if (busy !== 1'b0 || pkt_cnt !== 32'(exp_pkt)) $display("FAIL lfsr_end got busy %b pkt %0d want 0 %0d", busy, pkt_cnt, exp_pkt); else passed++;
    endtask

    task automatic test_gap();
        int n = 0;
        setup(2'd0, 2, 5, 4'hF);
        enable = 1'b1;
        @(negedge clk);
        checks++; if (tdata !== 32'h0 || tvalid !== 1'b1) $display("FAIL gap_b0 got %h/%b want 0/1", tdata, tvalid); else passed++;
        @(negedge clk);
        checks++; if (tlast !== 1'b1) $display("FAIL gap_b1_last got %b want 1", tlast); else passed++;
        @(negedge clk);
        while (tvalid === 1'b0 && n < 20) begin
            checks++; if (busy !== 1'b1) $display("FAIL gap_busy cyc %0d got %b want 1", n, busy); else passed++;
            n++;
            @(negedge clk);
        end
        checks++; if (n != 5) $display("FAIL gap_len got %0d idle cycles want 5", n); else passed++;
        $display("gap: %0d idle cycles between bursts", n);
        checks++; if (tdata !== 32'h0 || tvalid !== 1'b1) $display("FAIL gap_next_b0 got %h/%b want 0/1", tdata, tvalid); else passed++;
        enable = 1'b0;
        @(negedge clk);
        checks++; if (tlast !== 1'b1 || tdata !== 32'h1) $display("FAIL gap_next_b1 got %h/%b want 1/1", tdata, tlast); else passed++;
        @(negedge clk);
        exp_pkt += 2;
        checks++; if (busy !== 1'b0 || tvalid !== 1'b0) $display("FAIL gap_early_stop got busy %b valid %b want 0 0", busy, tvalid); else passed++;
        checks++; if (pkt_cnt !== 32'(exp_pkt)) $display("FAIL gap_pkt got %0d want %0d", pkt_cnt, exp_pkt); else passed++;
    endtask

    task automatic test_edge();
        int n = 0;
        logic done = 1'b0;
        setup(2'd0, 0, 0, 4'hF);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0 || tvalid !== 1'b0) $display("FAIL len0 cyc %0d got busy %b valid %b want 0 0", i, busy, tvalid); else passed++;
        end
        burst_len = LEN_W'(MAXB + 1);
        @(negedge clk);
        enable = 1'b0;
        while (!done && n < 20) begin
            checks++; if (tdata !== 32'(n) || tvalid !== 1'b1) $display("FAIL clamp beat %0d got %h/%b want %h/1", n, tdata, tvalid, 32'(n)); else passed++;
            if (tlast === 1'b1) done = 1'b1;
            else begin
                n++;
                @(negedge clk);
            end
        end
        checks++; if (n + 1 != MAXB) $display("FAIL clamp_len got %0d beats want %0d", n + 1, MAXB); else passed++;
        $display("clamp: burst of %0d beats", n + 1);
        @(negedge clk);
        exp_pkt += 1;
        checks++; if (busy !== 1'b0 || pkt_cnt !== 32'(exp_pkt)) $display("FAIL clamp_end got busy %b pkt %0d want 0 %0d", busy, pkt_cnt, exp_pkt); else passed++;
    endtask

    task automatic test_async_reset();
        int n = 0;
        setup(2'd0, 4, 0, 4'hF);
        tready = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tdata !== 32'h2) $display("FAIL ar_pre got %h want 2", tdata); else passed++;
        tready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (tvalid !== 1'b0 || busy !== 1'b0) $display("FAIL ar_immediate got valid %b busy %b want 0 0", tvalid, busy); else passed++;
        checks++; if (tdata !== 32'h0 || tkeep !== 4'h0 || tlast !== 1'b0) $display("FAIL ar_data got %h/%h/%b want 0/0/0", tdata, tkeep, tlast); else passed++;
        checks++; if (pkt_cnt !== 32'd0) $display("FAIL ar_pkt got %0d want 0", pkt_cnt); else passed++;
        $display("async reset: valid %b busy %b pkt %0d", tvalid, busy, pkt_cnt);
        @(negedge clk);
        rst_n = 1'b1;
        tready = 1'b1;
        @(negedge clk);
        checks++; if (tvalid !== 1'b1 || tdata !== 32'h0) $display("FAIL ar_restart got %b/%h want 1/0", tvalid, tdata); else passed++;
        enable = 1'b0;
        while (tlast !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n != 3) $display("FAIL ar_len got last after %0d cycles want 3", n); else passed++;
        @(negedge clk);
        checks++; if (pkt_cnt !== 32'd1 || busy !== 1'b0) $display("FAIL ar_end got pkt %0d busy %b want 1 0", pkt_cnt, busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_counter();
        test_backpressure();
        test_modes();
        test_lfsr();
        test_gap();
        test_edge();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axis_pattern_generator.md
AXIS_PATTERN_GENERATOR -- requirements
Module: axis_pattern_generator

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 32, tdata width; multiple of 8, range 8..512.
REQ-002 SHALL have parameter MAX_BURST, default 1024, largest burst length in beats; range 1..65536.
REQ-003 SHALL have parameter GAP_WIDTH, default 8, width of the inter-burst gap counter.
REQ-004 SHALL use one clock, clk_i, and reset a_rst_n_i, which is asynchronous and active-low.
REQ-005 SHALL have ports:
- clk_i  in  1  clock.
- a_rst_n_i  in  1  async active-low reset.
- enable_i  in  1  start and continue bursts.
- mode_i  in  2  pattern select, sampled at burst start.
- burst_len_i  in  $clog2(MAX_BURST+1)  beats per burst, sampled at burst start.
- gap_i  in  GAP_WIDTH  idle cycles between bursts, sampled at burst start.
- last_tkeep_i  in  AXIS_DATA_WIDTH/8  tkeep for the last beat, sampled at burst start.
- m_axis_tdata_o  out  AXIS_DATA_WIDTH  data.
- m_axis_tkeep_o  out  AXIS_DATA_WIDTH/8  byte enables.
- m_axis_tvalid_o  out  1  valid.
- m_axis_tlast_o  out  1  last beat of a burst.
- m_axis_tready_i  in  1  ready.
- busy_o  out  1  FSM not in IDLE.
- pkt_cnt_o  out  32  count of completed bursts.

Function
REQ-006 SHALL implement FSM IDLE, SEND, GAP.
REQ-007 IDLE -> SEND on the first edge with enable_i=1 and burst_len_i!=0.
- On that edge, mode, length, gap and last_tkeep SHALL be latched.
- tvalid SHALL rise one cycle after the enable_i sample.
- burst_len_i=0 SHALL keep the FSM in IDLE.
- burst_len_i>MAX_BURST SHALL be clamped to MAX_BURST.
REQ-008 A beat SHALL transfer only when tvalid&tready are both high.
- While tvalid&!tready, tdata, tkeep and tlast SHALL hold stable.
- tvalid SHALL never drop before its handshake.
REQ-009 Beat index k (0..len-1) SHALL advance only on a handshake.
- tlast=1 exactly on k=len-1.
- tkeep SHALL be all-ones except on the last beat, which uses the latched last_tkeep.
REQ-010 After the last handshake, the next state SHALL be chosen as follows:
- enable_i=1, gap=0: stay in SEND, relatch inputs, next burst back-to-back with tvalid held high.
- enable_i=1, gap>0: go to GAP for exactly gap cycles with tvalid=0, then SEND and relatch inputs.
- enable_i=0: go to IDLE.
REQ-011 Deasserting enable_i mid-burst SHALL NOT truncate the burst; the burst completes, then IDLE.
REQ-012 Deasserting enable_i during GAP SHALL return the FSM to IDLE at gap end.
REQ-013 Data per mode:
- 0 = counter: k zero-extended.
- 1 = walking one: 1<<(k mod AXIS_DATA_WIDTH).
- 2 = LFSR: 32-bit state replicated and truncated to width.
- 3 = reserved: behaves as mode 0.
REQ-014 The LFSR SHALL be Galois, right-shifting, with tap mask 32'h80200003 and seed 32'h00000001.
- It SHALL advance only on handshakes in mode 2.
- It SHALL NOT reseed between bursts.
REQ-015 pkt_cnt_o SHALL increment on each tlast handshake and wrap from 2^32-1 to 0.

Reset
REQ-016 Asserting a_rst_n_i SHALL immediately set the following, regardless of FSM state or burst progress:
- FSM to IDLE.
- tvalid, tlast, busy_o to 0.
- tdata to 0 and tkeep to 0.
- pkt_cnt_o to 0.
- LFSR to its seed.
- All latched configuration to 0.
REQ-017 After deassertion, the first burst SHALL start at k=0.

Configuration
REQ-018 Macro AXIS_PATTERN_GENERATOR_LFSR_EN SHALL control whether the LFSR is built.
- Defined: mode 2 is the LFSR per REQ-014.
- Undefined: no LFSR logic is built, and mode 2 behaves as mode 0.

Structure
REQ-019 Package axis_pattern_generator_pkg SHALL hold the following; the top SHALL use no other literals for these:
- mode encodings.
- FSM state encoding.
- LFSR tap mask and seed.
REQ-020 The LFSR SHALL be sub-module axis_pattern_generator_lfsr, with ports clk_i, a_rst_n_i, advance_i and state_o[31:0].

Verification
REQ-021 Counter mode: mode=0, len=4, gap=0, tready=1, enable held.
- Response: tdata 0,1,2,3,0,... with tlast on every 4th beat.
- pkt_cnt_o increments every 4 cycles with no tvalid bubble.
REQ-022 Backpressure and tkeep: AXIS_DATA_WIDTH=32, len=3, last_tkeep=4'h3, tready toggles 1/0.
- Response: data and tkeep stable while stalled.
- tkeep sequence f, f, 3.
REQ-023 LFSR mode: mode=2, LFSR_EN defined.
- Response: beats 32'h00000001 then 32'h80200003.
- With the macro undefined, the same stimulus returns 0, 1.
REQ-024 Gap and early stop: len=2, gap=5, enable drops during beat 0.
- Response: the burst completes, then IDLE, with no GAP.
- With enable held, exactly 5 tvalid=0 cycles between bursts.
REQ-025 Edge inputs: burst_len_i=0 keeps the FSM in IDLE; burst_len_i=MAX_BURST+1 yields a burst of MAX_BURST beats.
REQ-026 Async reset: assert a_rst_n_i mid-burst with tready=0.
- Response: tvalid=0 and busy_o=0 before the next clock edge.
- Next burst starts at k=0 and pkt_cnt_o=0.
